instr_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned INSTR_BYTES = 4;
    // Widest PC a queue entry can carry; the top zero-extends narrower PCs.
    localparam int unsigned PC_MAX_W    = 64;

    // Fetch FSM encoding
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t FETCH = 2'd0;
    localparam fetch_state_t STALL = 2'd1;
    localparam fetch_state_t FAULT = 2'd2;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs with flush and push+pop when full.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t e0_q, e1_q;
    logic [1:0]   count_q;
    logic         pop_ok;

    assign pop_ok = pop && (count_q != 2'd0);

    // Entry 0 is always the head; entries shift down on pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_q    <= din;
                        count_q <= 2'd1;
                    end else if (count_q == 2'd1) begin
                        e1_q    <= din;
                        count_q <= 2'd2;
                    end
                end
                2'b01: begin
                    e0_q    <= e1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_q <= din;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = (count_q != 2'd0) ? e0_q : '0;
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, waits WAIT_CYCLES for the memory read,
// queues fetched words and hands them to decode over valid/ready.
// Optional macro IFETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 64,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       WAIT_CYCLES = 1,
    parameter int unsigned       MEM_BYTES   = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall,
`endif
    output logic              fault
);

    localparam int unsigned      CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [ADDR_W:0]  MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    fetch_state_t      state_q, state_d;
    logic              fault_q, fault_d;

    logic              push, pop, pop_req, flush, sample, bad_pc, space;
    logic [ADDR_W:0]   pc_end;
    logic [1:0]        q_count;
    fetch_entry_t      q_din, q_head;

    // One bit wider so the last-byte address never wraps past the bound.
    assign pc_end  = {1'b0, pc_q} + (ADDR_W + 1)'(INSTR_BYTES - 1);
    assign bad_pc  = (pc_q[1:0] != 2'b00) || (pc_end >= MEM_LIMIT);
    assign sample  = (cnt_q == CNT_LAST);
    assign pop_req = out_valid && out_ready;
    assign pop     = pop_req && !redirect_valid;
    assign space   = (q_count < 2'd2) || pop_req;

    // Next-state: redirect flushes everything, otherwise sample/stall/fault.
    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        fault_d = fault_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_d    = redirect_pc;
            cnt_d   = '0;
            fault_d = 1'b0;
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH, STALL: begin
                    if (sample) begin
                        if (bad_pc) begin
                            fault_d = 1'b1;
                            state_d = FAULT;
                        end else if (space) begin
                            push    = 1'b1;
                            pc_d    = pc_q + ADDR_W'(INSTR_BYTES);
                            cnt_d   = '0;
                            state_d = FETCH;
                        end else begin
                            state_d = STALL;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                FAULT: ;
                default: state_d = FETCH;
            endcase
        end
    end

    // PC, wait counter, FSM state and sticky fault.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            state_q <= FETCH;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    assign q_din = '{pc: PC_MAX_W'(pc_q), instr: imem_data};

    fetch_queue u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (q_din),
        .head  (q_head),
        .count (q_count)
    );

    assign imem_addr = pc_q;
    assign fault     = fault_q;
    assign out_valid = (q_count != 2'd0);
    assign out_instr = q_head.instr;
    assign out_pc    = q_head.pc[ADDR_W-1:0];

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    // Saturating counters of pushes and of cycles spent stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
            if ((state_q == STALL) && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: two DUTs (WAIT_CYCLES=1 and 3) share stimulus and
// are checked each cycle against a queue-level model, plus literal expectations.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_ready = 1'b1;

    logic [63:0] imem_addr1, imem_addr3, out_pc1, out_pc3;
    logic [31:0] imem_data1, imem_data3, out_instr1, out_instr3;
    logic        out_valid1, out_valid3, fault1, fault3;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched1, perf_stall1, perf_fetched3, perf_stall3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [512];

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(logic [63:0] a);
        int i;
        i = int'(a[8:0]);
        if (a <= 64'd508) return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
        return 32'hdeadbeef;
    endfunction

    assign imem_data1 = rd(imem_addr1);
    assign imem_data3 = rd(imem_addr3);

    instr_fetch_unit #(.ADDR_W(64), .RESET_PC(64'd0), .WAIT_CYCLES(1), .MEM_BYTES(512)) dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr1),
        .imem_data      (imem_data1),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid1),
        .out_ready      (out_ready),
        .out_instr      (out_instr1),
        .out_pc         (out_pc1),
`ifdef IFETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched1),
        .perf_stall     (perf_stall1),
`endif
        .fault          (fault1)
    );

    instr_fetch_unit #(.ADDR_W(64), .RESET_PC(64'd0), .WAIT_CYCLES(3), .MEM_BYTES(512)) dut3 (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr3),
        .imem_data      (imem_data3),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid3),
        .out_ready      (out_ready),
        .out_instr      (out_instr3),
        .out_pc         (out_pc3),
`ifdef IFETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched3),
        .perf_stall     (perf_stall3),
`endif
        .fault          (fault3)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: per DUT a list of up to two queued words, the fetch PC,
    // edges elapsed since the address last changed, and sticky fault.
    int          m_n     [2] = '{0, 0};
    logic [63:0] m_qpc   [2][2];
    logic [31:0] m_qin   [2][2];
    logic [63:0] m_pc    [2] = '{64'd0, 64'd0};
    int          m_since [2] = '{0, 0};
    bit          m_fault [2] = '{1'b0, 1'b0};
    bit          m_stall [2] = '{1'b0, 1'b0};
    logic [31:0] m_pf    [2] = '{32'd0, 32'd0};
    logic [31:0] m_ps    [2] = '{32'd0, 32'd0};

    task automatic qpop(int k);
        m_qpc[k][0] = m_qpc[k][1];
        m_qin[k][0] = m_qin[k][1];
        m_n[k]--;
    endtask

    task automatic step(int k, int w);
        bit          pop;
        logic [64:0] endb;
        pop = (m_n[k] > 0) && (out_ready === 1'b1);
        if (rst_n !== 1'b1) begin
            m_n[k] = 0; m_pc[k] = 64'd0; m_since[k] = 0; m_fault[k] = 1'b0;
            m_stall[k] = 1'b0; m_pf[k] = 32'd0; m_ps[k] = 32'd0;
            return;
        end
        if (m_stall[k] && (m_ps[k] != 32'hffffffff)) m_ps[k]++;
        if (redirect_valid === 1'b1) begin
            m_n[k] = 0; m_pc[k] = redirect_pc; m_since[k] = 0;
            m_fault[k] = 1'b0; m_stall[k] = 1'b0;
            return;
        end
        if (m_fault[k]) begin
            if (pop) qpop(k);
            return;
        end
        if (m_since[k] + 1 < w) begin
            m_since[k]++;
            if (pop) qpop(k);
            return;
        end
        endb = {1'b0, m_pc[k]} + 65'd3;
        if ((m_pc[k] % 64'd4 != 64'd0) || (endb >= 65'd512)) begin
            m_fault[k] = 1'b1;
            m_stall[k] = 1'b0;
            if (pop) qpop(k);
        end else if (m_n[k] < 2 || pop) begin
            if (pop) qpop(k);
            m_qpc[k][m_n[k]] = m_pc[k];
            m_qin[k][m_n[k]] = rd(m_pc[k]);
            m_n[k]++;
            m_pc[k] = m_pc[k] + 64'd4;
            m_since[k] = 0;
            m_stall[k] = 1'b0;
            if (m_pf[k] != 32'hffffffff) m_pf[k]++;
        end else begin
            m_stall[k] = 1'b1;
        end
    endtask

    task automatic cmp_dut(int k, int w, logic ov, logic [31:0] oi, logic [63:0] op,
                           logic [63:0] ia, logic f);
        string p;
        p = $sformatf("w%0d", w);
        chk({p, " out_valid"}, 64'(ov), 64'(m_n[k] > 0));
        chk({p, " out_instr"}, 64'(oi), (m_n[k] > 0) ? 64'(m_qin[k][0]) : 64'd0);
        chk({p, " out_pc"}, op, (m_n[k] > 0) ? m_qpc[k][0] : 64'd0);
        chk({p, " imem_addr"}, ia, m_pc[k]);
        chk({p, " fault"}, 64'(f), 64'(m_fault[k]));
    endtask

    // Model advances on the edge with the inputs seen there; outputs compared after.
    always @(posedge clk) begin
        step(0, 1);
        step(1, 3);
        #2;
        cmp_dut(0, 1, out_valid1, out_instr1, out_pc1, imem_addr1, fault1);
        cmp_dut(1, 3, out_valid3, out_instr3, out_pc3, imem_addr3, fault3);
`ifdef IFETCH_PERF_CNT_EN
        chk("w1 perf_fetched", 64'(perf_fetched1), 64'(m_pf[0]));
        chk("w1 perf_stall", 64'(perf_stall1), 64'(m_ps[0]));
        chk("w3 perf_fetched", 64'(perf_fetched3), 64'(m_pf[1]));
        chk("w3 perf_stall", 64'(perf_stall3), 64'(m_ps[1]));
`endif
    end

    task automatic put(int a, logic [31:0] wd);
        mem[a]   = wd[7:0];
        mem[a+1] = wd[15:8];
        mem[a+2] = wd[23:16];
        mem[a+3] = wd[31:24];
    endtask

    task automatic head1(string name, logic [63:0] pc, logic [31:0] ins);
        chk({name, " valid"}, 64'(out_valid1), 64'd1);
        chk({name, " pc"}, out_pc1, pc);
        chk({name, " instr"}, 64'(out_instr1), 64'(ins));
    endtask

    logic [31:0] prog [4];

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        prog[0] = 32'h8b1f03e5; prog[1] = 32'hf84000a4;
        prog[2] = 32'h8b040086; prog[3] = 32'hf80010a6;
        for (int i = 0; i < 4; i++) put(4 * i, prog[i]);
        put(508, 32'h13579bdf);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset valid1", 64'(out_valid1), 64'd0);
        chk("reset addr1", imem_addr1, 64'd0);
        chk("reset instr1", 64'(out_instr1), 64'd0);
        chk("reset pc3", out_pc3, 64'd0);
        chk("reset fault3", 64'(fault3), 64'd0);
        rst_n = 1'b1;

        // Streaming: one word per cycle for W=1, one per three cycles for W=3
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c <= 4) head1($sformatf("stream%0d", c), 64'(4 * (c - 1)), prog[c-1]);
            chk($sformatf("w3 spacing c%0d", c), 64'(out_valid3), 64'((c % 3) == 0));
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midwait reset valid3", 64'(out_valid3), 64'd0);
        chk("midwait reset addr3", imem_addr3, 64'd0);
        chk("midwait reset instr3", 64'(out_instr3), 64'd0);
        chk("midwait reset addr1", imem_addr1, 64'd0);

        // Backpressure from reset: two entries queued, address held at 8
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        head1("stall head", 64'd0, prog[0]);
        chk("stall addr", imem_addr1, 64'd8);
        out_ready = 1'b1;
        @(negedge clk); head1("drain1", 64'd4, prog[1]);
        @(negedge clk); head1("drain2", 64'd8, prog[2]);
        @(negedge clk); head1("drain3", 64'd12, prog[3]);

        // Redirect while full
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 64'd8;
        @(negedge clk);
        chk("redir flush valid", 64'(out_valid1), 64'd0);
        chk("redir addr", imem_addr1, 64'd8);
        redirect_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); head1("redir target", 64'd8, prog[2]);

        // Misaligned redirect faults, aligned redirect clears it
        redirect_valid = 1'b1; redirect_pc = 64'd6;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("misalign fault", 64'(fault1), 64'd1);
        chk("misalign valid", 64'(out_valid1), 64'd0);
        @(negedge clk);
        chk("misalign hold addr", imem_addr1, 64'd6);
        redirect_valid = 1'b1; redirect_pc = 64'd4;
        @(negedge clk);
        chk("refetch fault clear", 64'(fault1), 64'd0);
        redirect_valid = 1'b0;
        @(negedge clk); head1("refetch", 64'd4, prog[1]);

        // Last word in range, then range fault
        redirect_valid = 1'b1; redirect_pc = 64'd508;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        head1("edge word", 64'd508, 32'h13579bdf);
        chk("edge no fault", 64'(fault1), 64'd0);
        @(negedge clk);
        chk("range fault", 64'(fault1), 64'd1);
        chk("range valid", 64'(out_valid1), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 299) != 0);
            if (((i / 400) % 2) == 1) out_ready = ($urandom_range(0, 3) == 0);
            else out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 7))
                0, 1, 2, 3: redirect_pc = 64'(4 * $urandom_range(0, 127));
                4:          redirect_pc = 64'(4 * $urandom_range(120, 127));
                5:          redirect_pc = 64'($urandom_range(0, 511));
                6:          redirect_pc = 64'(512 + 4 * $urandom_range(0, 3));
                default:    redirect_pc = 64'd0;
            endcase
        end
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
